pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage CPU. It merges stall requests from the ID, EX and MEM stages into the 6-bit stall vector consumed by every pipeline register: the PC register, if_id, id_ex, ex_mem and mem_wb. It also contains the multi-cycle execute sequencer, a counter-based FSM that holds the pipeline while an EX-stage iterative operation (div, madd/msub) completes. A saturating stall-cycle counter is provided for performance monitoring.

---
 rtl/pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl : central pipeline controller for the 5-stage CPU.
//
// Merges stall requests from ID, EX and MEM into the 6-bit stall vector that
// drives every pipeline register, and sequences EX-stage multi-cycle operations
// (div, madd/msub) with a down-counter FSM. A saturating counter tracks how many
// cycles the pipeline spent with any stall bit set.
//
// Ports:
//   clk                system clock, rising edge
//   rst                synchronous reset, active-high
//   stallreq_from_id   load-use hazard request from decode
//   stallreq_from_mem  data-bus wait request from memory stage
//   ex_mc_start        EX holds a multi-cycle op (level while op sits in EX)
//   ex_mc_cycles       op length N in cycles, valid with ex_mc_start
//   flush              abort sequencer (exception/redirect)
//   stall[5:0]         [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
//   mc_busy            sequencer is counting (RUN)
//   mc_done            result-valid phase, EX may write its result
//   mc_cnt             remaining cycles (debug)
//   stall_cycles       saturating count of cycles with stall != 0
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_mem,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_cycles,
  input  logic              flush,
  output logic [5:0]        stall,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [CNT_W-1:0]  mc_cnt,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [PERF_W-1:0] perf_r;
  logic              start_s;
  logic              stallreq_ex_s;
  logic [5:0]        stall_s;

  // EX stall request: a zero-length op never starts the sequencer, and DONE
  // deliberately releases the pipeline so the finished op can advance.
  always_comb begin
    start_s       = ex_mc_start && (ex_mc_cycles != CNT_ZERO) && !flush;
    stallreq_ex_s = ((state_r == IDLE) && start_s) || (state_r == RUN);
  end

  // Stall merge, highest priority first. Each pattern freezes a contiguous
  // low-order run of registers, so the first non-frozen register gets a bubble.
  always_comb begin
    stall_s = 6'b000000;
    if (flush) begin
      stall_s = 6'b000000;
    end else if (stallreq_from_mem) begin
      stall_s = 6'b011111;
    end else if (stallreq_ex_s) begin
      stall_s = 6'b001111;
    end else if (stallreq_from_id) begin
      stall_s = 6'b000111;
    end else begin
      stall_s = 6'b000000;
    end
  end

  // Sequencer next-state and down-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (flush) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = ex_mc_cycles;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          // Counting ignores MEM stalls so RUN always lasts exactly N cycles.
          cnt_nxt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DONE: begin
          // ex_mc_start is ignored here: the same op is still in EX. Leave only
          // on the cycle EX/MEM is not frozen, i.e. when the op moves on.
          if (stall_s[3]) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and saturating stall-cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      perf_r  <= {PERF_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if ((stall_s != 6'b000000) && (perf_r != PERF_MAX)) begin
        perf_r <= perf_r + PERF_ONE;
      end else begin
        perf_r <= perf_r;
      end
    end
  end

  // Outputs: reset masks the combinational controls immediately.
  always_comb begin
    stall        = rst ? 6'b000000 : stall_s;
    mc_busy      = !rst && (state_r == RUN);
    mc_done      = !rst && (state_r == DONE) && !flush;
    mc_cnt       = cnt_r;
    stall_cycles = perf_r;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_id;
  logic        stallreq_from_mem;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush;
  logic [5:0]  stall;
  logic        mc_busy;
  logic        mc_done;
  logic [5:0]  mc_cnt;
  logic [31:0] stall_cycles;

  // Second instance with a narrow perf counter to reach saturation quickly.
  logic [5:0]  s_stall;
  logic        s_busy;
  logic        s_done;
  logic [5:0]  s_cnt;
  logic [3:0]  s_perf;

  pipe_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_id(stallreq_from_id), .stallreq_from_mem(stallreq_from_mem),
    .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles), .flush(flush),
    .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done), .mc_cnt(mc_cnt),
    .stall_cycles(stall_cycles)
  );

  pipe_ctrl #(.CNT_W(6), .PERF_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .stallreq_from_id(stallreq_from_id), .stallreq_from_mem(stallreq_from_mem),
    .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles), .flush(flush),
    .stall(s_stall), .mc_busy(s_busy), .mc_done(s_done), .mc_cnt(s_cnt),
    .stall_cycles(s_perf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] stall;
    logic       busy;
    logic       done;
    logic [5:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc_no   = 0;
  string       phase    = "reset";
  logic [31:0] perf_m   = 32'd0;
  logic [3:0]  sat_m    = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s cyc=%0d observed=%0h expected=%0h", phase, tag, cyc_no, obs, exp);
    end
  endtask

  // Push the expectation for the current cycle, compare at the falling edge,
  // advance the perf models, then move to just after the next rising edge.
  task automatic step(input logic [5:0] s, input logic b, input logic d, input logic [5:0] c);
    exp_t e;
    e.stall = s; e.busy = b; e.done = d; e.cnt = c;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("stall",  {26'd0, stall}, {26'd0, e.stall});
    chk("busy",   {31'd0, mc_busy}, {31'd0, e.busy});
    chk("done",   {31'd0, mc_done}, {31'd0, e.done});
    chk("cnt",    {26'd0, mc_cnt}, {26'd0, e.cnt});
    chk("perf",   stall_cycles, perf_m);
    chk("perf4",  {28'd0, s_perf}, {28'd0, sat_m});
    if (rst) begin
      perf_m = 32'd0;
      sat_m  = 4'd0;
    end else if (e.stall != 6'd0) begin
      if (perf_m != 32'hFFFF_FFFF) perf_m = perf_m + 32'd1;
      if (sat_m != 4'hF) sat_m = sat_m + 4'd1;
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stallreq_from_id = 1'b0; stallreq_from_mem = 1'b0;
    ex_mc_start = 1'b0; ex_mc_cycles = 6'd0; flush = 1'b0;
    @(posedge clk); #1;
    step(6'b000000, 1'b0, 1'b0, 6'd0);
    rst = 1'b0;

    // Isolated requests
    phase = "iso";
    stallreq_from_id = 1'b1;  step(6'b000111, 1'b0, 1'b0, 6'd0);
    stallreq_from_id = 1'b0; stallreq_from_mem = 1'b1;
    step(6'b011111, 1'b0, 1'b0, 6'd0);
    stallreq_from_mem = 1'b0; step(6'b000000, 1'b0, 1'b0, 6'd0);

    // N=3, start held through DONE
    phase = "n3";
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd3;
    step(6'b001111, 1'b0, 1'b0, 6'd0);
    step(6'b001111, 1'b1, 1'b0, 6'd3);
    step(6'b001111, 1'b1, 1'b0, 6'd2);
    step(6'b001111, 1'b1, 1'b0, 6'd1);
    step(6'b000000, 1'b0, 1'b1, 6'd0);
    ex_mc_start = 1'b0;
    step(6'b000000, 1'b0, 1'b0, 6'd0);

    // N=3 with MEM stall t3..t6
    phase = "n3mem";
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd3;
    step(6'b001111, 1'b0, 1'b0, 6'd0);
    step(6'b001111, 1'b1, 1'b0, 6'd3);
    step(6'b001111, 1'b1, 1'b0, 6'd2);
    stallreq_from_mem = 1'b1;
    step(6'b011111, 1'b1, 1'b0, 6'd1);
    step(6'b011111, 1'b0, 1'b1, 6'd0);
    step(6'b011111, 1'b0, 1'b1, 6'd0);
    step(6'b011111, 1'b0, 1'b1, 6'd0);
    stallreq_from_mem = 1'b0;
    step(6'b000000, 1'b0, 1'b1, 6'd0);
    ex_mc_start = 1'b0;
    step(6'b000000, 1'b0, 1'b0, 6'd0);

    // Flush at t2 of N=5
    phase = "flush";
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd5;
    step(6'b001111, 1'b0, 1'b0, 6'd0);
    step(6'b001111, 1'b1, 1'b0, 6'd5);
    flush = 1'b1;
    step(6'b000000, 1'b1, 1'b0, 6'd4);
    flush = 1'b0; ex_mc_start = 1'b0;
    step(6'b000000, 1'b0, 1'b0, 6'd0);

    // Start together with MEM stall, N=2
    phase = "startmem";
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd2; stallreq_from_mem = 1'b1;
    step(6'b011111, 1'b0, 1'b0, 6'd0);
    stallreq_from_mem = 1'b0;
    step(6'b001111, 1'b1, 1'b0, 6'd2);
    step(6'b001111, 1'b1, 1'b0, 6'd1);
    step(6'b000000, 1'b0, 1'b1, 6'd0);
    ex_mc_start = 1'b0;
    step(6'b000000, 1'b0, 1'b0, 6'd0);

    // N=0 is single-cycle: no stall, no state change
    phase = "n0";
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd0;
    step(6'b000000, 1'b0, 1'b0, 6'd0);
    step(6'b000000, 1'b0, 1'b0, 6'd0);
    ex_mc_start = 1'b0;

    // Reset mid-RUN, N=10, rst at t4
    phase = "rstrun";
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd10;
    step(6'b001111, 1'b0, 1'b0, 6'd0);
    step(6'b001111, 1'b1, 1'b0, 6'd10);
    step(6'b001111, 1'b1, 1'b0, 6'd9);
    step(6'b001111, 1'b1, 1'b0, 6'd8);
    rst = 1'b1;
    step(6'b000000, 1'b0, 1'b0, 6'd7);
    rst = 1'b0; ex_mc_start = 1'b0;
    step(6'b000000, 1'b0, 1'b0, 6'd0);

    // Perf: 7 ID-stall cycles, then saturate the narrow counter
    phase = "perf";
    stallreq_from_id = 1'b1;
    for (int i = 0; i < 7; i++) step(6'b000111, 1'b0, 1'b0, 6'd0);
    stallreq_from_id = 1'b0;
    step(6'b000000, 1'b0, 1'b0, 6'd0);
    chk("perf7", stall_cycles, 32'd7);
    phase = "sat";
    stallreq_from_id = 1'b1;
    for (int i = 0; i < 12; i++) step(6'b000111, 1'b0, 1'b0, 6'd0);
    stallreq_from_id = 1'b0;
    step(6'b000000, 1'b0, 1'b0, 6'd0);
    chk("sat15", {28'd0, s_perf}, 32'd15);
    chk("perf19", stall_cycles, 32'd19);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
